crash_handler: RTL

Frame-rate game-state stage directly downstream of the per-pixel collision detector. Accumulates the pixel-rate `crash_enemy_bullet` / `crash_me_enemy` strobes over each video frame, then at frame end updates score, lives, invincibility and enemy-explosion animation, and issues respawn/clear pulses to the sprite generators. Owns the top-level game FSM (idle / play / invincible / over).

---
 rtl/game_pkg.sv | 21 ++
 rtl/explode_anim.sv | 36 +++
 rtl/crash_handler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game-state encodings and constants for crash_handler and the sprite blocks.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_INVINC = 2'd2,
    ST_OVER   = 2'd3
  } game_state_t;

  localparam int EXPL_W          = 2;
  localparam int EXPL_CNT_W      = 4;
  localparam int INV_W           = 8;
  localparam int LIVES_INIT_DEF  = 3;
  localparam int ENEMY_SCORE_DEF = 10;

  localparam logic [EXPL_W-1:0] EXPL_NONE  = 2'd0;
  localparam logic [EXPL_W-1:0] EXPL_FIRST = 2'd1;
  localparam logic [EXPL_W-1:0] EXPL_LAST  = 2'd3;

endpackage

// File: rtl/explode_anim.sv
// Enemy explosion animation: sprite index 1->2->3->0, advancing every STEP frame ends.
module explode_anim
  import game_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_end_i,
  input  logic              restart_i,
  output logic [EXPL_W-1:0] index_o
);

  localparam logic [EXPL_CNT_W-1:0] STEP_LOAD = EXPL_CNT_W'(STEP);

  logic [EXPL_CNT_W-1:0] step_cnt;

  // Restart arrives on the scoring frame end, so it takes priority over stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      index_o  <= EXPL_NONE;
    end else if (restart_i) begin
      step_cnt <= STEP_LOAD;
      index_o  <= EXPL_FIRST;
    end else if (frame_end_i && (index_o != EXPL_NONE)) begin
      if (step_cnt <= EXPL_CNT_W'(1)) begin
        step_cnt <= STEP_LOAD;
        index_o  <= (index_o == EXPL_LAST) ? EXPL_NONE : index_o + EXPL_W'(1);
      end else begin
        step_cnt <= step_cnt - EXPL_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/crash_handler.sv
// Frame-rate game state: folds pixel-rate crash strobes into per-frame score, lives,
// invincibility and explosion updates, and owns the idle/play/invincible/over FSM.
module crash_handler
  import game_pkg::*;
#(
  parameter int SCORE_W       = 16,
  parameter int ENEMY_SCORE   = ENEMY_SCORE_DEF,
  parameter int LIVES_INIT    = LIVES_INIT_DEF,
  parameter int INVINC_FRAMES = 120,
  parameter int EXPLODE_STEP  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               frame_end_i,
  input  logic               crash_enemy_bullet_i,
  input  logic               crash_me_enemy_i,
  output logic [1:0]         state_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [1:0]         lives_o,
  output logic               enemy_hit_o,
  output logic               bullet_clear_o,
  output logic [EXPL_W-1:0]  explode_frame_o,
  output logic               me_blink_o
);

  // state     | meaning
  // ST_IDLE   | after reset, waiting for start; crashes ignored
  // ST_PLAY   | normal play; enemy hits score, player hit costs a life
  // ST_INVINC | post-hit grace period; player hits ignored, player blinks
  // ST_OVER   | lives exhausted; score/lives frozen until start

  localparam logic [SCORE_W:0]   SCORE_INC  = (SCORE_W+1)'(ENEMY_SCORE);
  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [INV_W-1:0]   INV_LOAD   = INV_W'(INVINC_FRAMES);

  game_state_t        state, state_nxt;
  logic [SCORE_W-1:0] score, score_nxt, score_sat;
  logic [SCORE_W:0]   score_sum;
  logic [1:0]         lives, lives_nxt;
  logic [INV_W-1:0]   inv_cnt, inv_nxt;
  logic               hit_enemy, hit_enemy_nxt;
  logic               hit_me, hit_me_nxt;
  logic               enemy_now, me_now;
  logic               enemy_hit_nxt;
  logic               blink_nxt;
  logic               restart;
  logic               scoring;

  assign enemy_now = hit_enemy | crash_enemy_bullet_i;
  assign me_now    = hit_me | crash_me_enemy_i;
  assign score_sum = {1'b0, score} + SCORE_INC;
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  assign scoring   = (state == ST_PLAY) || (state == ST_INVINC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      score       <= '0;
      lives       <= '0;
      inv_cnt     <= '0;
      hit_enemy   <= 1'b0;
      hit_me      <= 1'b0;
      enemy_hit_o <= 1'b0;
      bullet_clear_o <= 1'b0;
      me_blink_o  <= 1'b0;
    end else begin
      state       <= state_nxt;
      score       <= score_nxt;
      lives       <= lives_nxt;
      inv_cnt     <= inv_nxt;
      hit_enemy   <= hit_enemy_nxt;
      hit_me      <= hit_me_nxt;
      enemy_hit_o <= enemy_hit_nxt;
      bullet_clear_o <= enemy_hit_nxt;
      me_blink_o  <= blink_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    score_nxt     = score;
    lives_nxt     = lives;
    inv_nxt       = inv_cnt;
    hit_enemy_nxt = enemy_now;
    hit_me_nxt    = me_now;
    enemy_hit_nxt = 1'b0;
    restart       = 1'b0;

    if (frame_end_i) begin
      hit_enemy_nxt = 1'b0;
      hit_me_nxt    = 1'b0;
    end

    // Scoring is resolved before the life loss so a fatal frame still counts its hit.
    if (frame_end_i && enemy_now && scoring) begin
      score_nxt     = score_sat;
      enemy_hit_nxt = 1'b1;
      restart       = 1'b1;
    end

    case (state)
      ST_IDLE, ST_OVER: begin
        if (start_i) begin
          state_nxt     = ST_PLAY;
          score_nxt     = '0;
          lives_nxt     = LIVES_LOAD;
          inv_nxt       = '0;
          hit_enemy_nxt = 1'b0;
          hit_me_nxt    = 1'b0;
        end
      end
      ST_PLAY: begin
        if (frame_end_i && me_now) begin
          if (lives <= 2'd1) begin
            state_nxt = ST_OVER;
            lives_nxt = '0;
          end else begin
            state_nxt = ST_INVINC;
            lives_nxt = lives - 2'd1;
            inv_nxt   = INV_LOAD;
          end
        end
      end
      ST_INVINC: begin
        if (frame_end_i) begin
          if (inv_cnt <= INV_W'(1)) begin
            state_nxt = ST_PLAY;
            inv_nxt   = '0;
          end else begin
            inv_nxt = inv_cnt - INV_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    blink_nxt = (state_nxt == ST_INVINC) && inv_nxt[3];
  end

  explode_anim #(
    .STEP (EXPLODE_STEP)
  ) u_explode (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_end_i (frame_end_i),
    .restart_i   (restart),
    .index_o     (explode_frame_o)
  );

  assign state_o = state;
  assign score_o = score;
  assign lives_o = lives;

endmodule
